als_sample_averager: RTL and testbench
======================================

# als_sample_averager

Downstream consumer of the ambient-light SPI master's receive stream. It assembles byte pairs into 16-bit ADC words and extracts the 8-bit light value. It smooths that value with a power-of-two moving average and shows the result in hex on the two 7-segment digits. It replaces the raw PWM-brightness path and adds framing checks and a flush control.

## Interface
Parameters:
- AVG_LOG2, 3: log2 of the moving-average window (window = 2^AVG_LOG2 samples). Legal range 0..4.

Ports:
- i_Clk  in  1  FPGA clock (25 MHz on target).
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_RX_DV  in  1  one-cycle byte-valid pulse from the SPI master.
- i_RX_Count  in  2  byte index within the CS frame: 0 = high byte, 1 = low byte.
- i_RX_Byte  in  8  received MISO byte.
- i_Flush  in  1  synchronous pulse; empties the average window.
- o_Sample  out  8  latest raw light value, ADC word bits [12:5].
- o_Sample_DV  out  1  one-cycle pulse with each new o_Sample.
- o_Avg  out  8  moving average.
- o_Avg_DV  out  1  one-cycle pulse with each new valid o_Avg.
- o_Err_Count  out  8  saturating count of framing errors.
- o_Segment1  out  7  high nibble of o_Avg, active-low; bit0 = A … bit6 = G.
- o_Segment2  out  7  low nibble of o_Avg, same encoding.

## Operation
- Assembler FSM, states WAIT_HI and WAIT_LO.
  - WAIT_HI, byte with count 0: store the high byte, go to WAIT_LO.
  - WAIT_LO, byte with count 1: form word = {hi, byte}; o_Sample = word[12:5]; pulse o_Sample_DV; go to WAIT_HI.
- Framing errors: each increments o_Err_Count, which saturates at 255.
  - WAIT_HI with count 1, 2 or 3: discard the byte, stay in WAIT_HI.
  - WAIT_LO with count 0: overwrite the stored high byte, stay in WAIT_LO.
  - WAIT_LO with count 2 or 3: discard the byte, return to WAIT_HI.
- Averager state: ring buffer of 2^AVG_LOG2 × 8-bit entries, write pointer, fill counter, and running sum of 8+AVG_LOG2 bits.
- On each accepted sample:
  - sum ← sum + new − buf[ptr]; buf[ptr] ← new; ptr wraps modulo window.
  - Fill counter saturates at the window size.
- Averaged output:
  - o_Avg = sum_new >> AVG_LOG2, truncating.
  - o_Avg_DV pulses only once the fill count has reached the window, i.e. from the 2^AVG_LOG2-th sample after reset or flush onward.
  - With AVG_LOG2 = 0, o_Avg equals each sample and o_Avg_DV pulses on every sample.
- Flush: clears buffer entries, sum, pointer and fill counter. The o_Avg value and the display hold their current contents. The assembler and o_Err_Count are unaffected.
- Flush in the same cycle as an accepted sample: flush wins. The sample still appears on o_Sample/o_Sample_DV but does not enter the window.
- Display:
  - Segments are registered and update from o_Avg on each o_Avg_DV.
  - Standard hex glyphs (0–9, A, b, C, d, E, F), active-low.
  - Before the first o_Avg_DV after reset, all segments read 1 (off).
- Reset values: FSM in WAIT_HI; o_Sample = 0; o_Avg = 0; all DV outputs 0; o_Err_Count = 0; buffer/sum/pointer/fill = 0; o_Segment1 and o_Segment2 = 7'h7F.

## Timing
- Cycle 0: i_RX_DV carrying the low byte.
- Cycle 1: o_Sample/o_Sample_DV.
- Cycle 2: o_Avg/o_Avg_DV.
- Cycle 3: segments.
- o_Err_Count updates 1 cycle after the offending byte.
- The block accepts i_RX_DV on consecutive cycles. The pipeline must sustain one sample every 2 cycles with no stalls and no backpressure.
- Reset asserted mid-frame returns the FSM to WAIT_HI immediately. A following lone count-1 byte is counted as an error.

## Test plan
- Bytes 0x0A (count 0) then 0xB0 (count 1), AVG_LOG2 = 0 -> o_Sample = 0x55 with one o_Sample_DV pulse; o_Avg = 0x55; o_Segment1 = o_Segment2 = 7'h12.
- AVG_LOG2 = 3, eight frames 0x0A/0xB0 -> o_Avg_DV absent for frames 1–7, first pulse on frame 8 with o_Avg = 0x55. Then frame 0x0B/0xA0 (sample 0x5D) -> o_Avg = 0x56.
- Lone count-1 byte at idle -> no o_Sample_DV, o_Err_Count = 1. Two count-0 bytes 0x01 then 0x0A, then count-1 byte 0xB0 -> o_Err_Count = 2, o_Sample = 0x55.
- 300 lone count-1 bytes -> o_Err_Count saturates at 0xFF.
- After a full window, i_Flush coincident with a sample -> o_Sample_DV pulses but no o_Avg_DV; o_Avg and display hold. The next o_Avg_DV arrives only after 8 further samples.
- i_Rst_L low for 1 cycle between a high byte and its low byte -> all outputs at reset values, segments 7'h7F; the late low byte gives o_Err_Count = 1.

Source files
------------

// File: rtl/als_sample_averager.sv
// Ambient-light sample path: assembles SPI byte pairs into ADC words, extracts the
// 8-bit light value, smooths it with a power-of-two moving average and drives two hex digits.
module als_sample_averager #(
  parameter int AVG_LOG2 = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [1:0] i_RX_Count,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Flush,
  output logic [7:0] o_Sample,
  output logic       o_Sample_DV,
  output logic [7:0] o_Avg,
  output logic       o_Avg_DV,
  output logic [7:0] o_Err_Count,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2
);

  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW  = 8 + AVG_LOG2;
  localparam int PW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW  = AVG_LOG2 + 1;

  // Handshake: i_RX_DV is a one-cycle strobe with no ready; every strobe is consumed
  // in the cycle it is seen, and each *_DV output is a one-cycle strobe likewise.
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  asm_state_t state_q, state_d;
  logic       load_hi, fire, frame_err;
  logic [4:0] hi_q;
  logic       flush_q;

  always_comb begin
    state_d   = state_q;
    load_hi   = 1'b0;
    fire      = 1'b0;
    frame_err = 1'b0;
    if (i_RX_DV) begin
      case (state_q)
        WAIT_HI: begin
          if (i_RX_Count == 2'd0) begin
            load_hi = 1'b1;
            state_d = WAIT_LO;
          end else begin
            frame_err = 1'b1;
          end
        end
        WAIT_LO: begin
          if (i_RX_Count == 2'd1) begin
            fire    = 1'b1;
            state_d = WAIT_HI;
          end else if (i_RX_Count == 2'd0) begin
            load_hi   = 1'b1;
            frame_err = 1'b1;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_HI;
          end
        end
        default: state_d = WAIT_HI;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= WAIT_HI;
    else          state_q <= state_d;
  end

  // Only word bits [12:5] are kept, so just the low five bits of the high byte matter.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hi_q        <= '0;
      o_Sample    <= '0;
      o_Sample_DV <= 1'b0;
      flush_q     <= 1'b0;
      o_Err_Count <= '0;
    end else begin
      o_Sample_DV <= fire;
      flush_q     <= i_Flush;
      if (load_hi) hi_q <= i_RX_Byte[4:0];
      if (fire) o_Sample <= {hi_q, i_RX_Byte[7:5]};
      if (frame_err && (o_Err_Count != 8'hFF)) o_Err_Count <= o_Err_Count + 8'd1;
    end
  end

  logic [7:0]    win_buf [WIN];
  logic [PW-1:0] ptr_q, ptr_new;
  logic [FW-1:0] fill_q, fill_new;
  logic [SW-1:0] sum_q, sum_new;

  always_comb begin
    sum_new  = sum_q + SW'(o_Sample) - SW'(win_buf[ptr_q]);
    ptr_new  = (ptr_q + PW'(1)) & PW'(WIN - 1);
    fill_new = (fill_q == FW'(WIN)) ? fill_q : fill_q + FW'(1);
  end

  // flush_q travels with o_Sample_DV, so a flush arriving with the low byte wins over it.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
      ptr_q    <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
      o_Avg    <= '0;
      o_Avg_DV <= 1'b0;
    end else begin
      o_Avg_DV <= 1'b0;
      if (flush_q) begin
        for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
        ptr_q  <= '0;
        fill_q <= '0;
        sum_q  <= '0;
      end else if (o_Sample_DV) begin
        win_buf[ptr_q] <= o_Sample;
        ptr_q          <= ptr_new;
        fill_q         <= fill_new;
        sum_q          <= sum_new;
        if (fill_new == FW'(WIN)) begin
          o_Avg    <= 8'(sum_new >> AVG_LOG2);
          o_Avg_DV <= 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Segment1 <= 7'h7F;
      o_Segment2 <= 7'h7F;
    end else if (o_Avg_DV) begin
      o_Segment1 <= hex_glyph(o_Avg[7:4]);
      o_Segment2 <= hex_glyph(o_Avg[3:0]);
    end
  end

endmodule

// File: tb/tb_als_sample_averager.sv
// Bench for als_sample_averager: window-8 and window-1 instances driven in parallel,
// checked against a queue-based moving-average model.
module tb_als_sample_averager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [1:0] rx_cnt = '0;
  logic [7:0] rx_byte = '0;
  logic       flush = 1'b0;

  logic [7:0] s3_sample, s3_avg, s3_err, s0_sample, s0_avg, s0_err;
  logic       s3_sample_dv, s3_avg_dv, s0_sample_dv, s0_avg_dv;
  logic [6:0] s3_seg1, s3_seg2, s0_seg1, s0_seg2;

  always #5 clk = ~clk;

  als_sample_averager #(.AVG_LOG2(3)) dut3 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Count(rx_cnt),
    .i_RX_Byte(rx_byte), .i_Flush(flush), .o_Sample(s3_sample), .o_Sample_DV(s3_sample_dv),
    .o_Avg(s3_avg), .o_Avg_DV(s3_avg_dv), .o_Err_Count(s3_err),
    .o_Segment1(s3_seg1), .o_Segment2(s3_seg2));

  als_sample_averager #(.AVG_LOG2(0)) dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Count(rx_cnt),
    .i_RX_Byte(rx_byte), .i_Flush(flush), .o_Sample(s0_sample), .o_Sample_DV(s0_sample_dv),
    .o_Avg(s0_avg), .o_Avg_DV(s0_avg_dv), .o_Err_Count(s0_err),
    .o_Segment1(s0_seg1), .o_Segment2(s0_seg2));

  int vecs = 0;
  int errs = 0;

  // Reference model: window contents since last flush, last valid averages, error count.
  logic [7:0] win_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_avg_q[$];
  logic [7:0] exp_avg3 = '0, exp_avg0 = '0;
  logic       seen3 = 1'b0, seen0 = 1'b0;
  int         exp_err = 0;
  logic       mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  function automatic logic [13:0] exp_segs(input logic seen, input logic [7:0] avg);
    if (!seen) return 14'h3FFF;
    return {glyph(avg[7:4]), glyph(avg[3:0])};
  endfunction

  function automatic void model_accept(input logic [7:0] samp, input logic fl,
                                       output logic v3, output logic v0);
    int s;
    if (fl) begin
      win_q.delete();
      v3 = 1'b0;
      v0 = 1'b0;
    end else begin
      win_q.push_back(samp);
      if (win_q.size() > 8) void'(win_q.pop_front());
      v3 = (win_q.size() == 8);
      if (v3) begin
        s = 0;
        foreach (win_q[i]) s += int'(win_q[i]);
        exp_avg3 = 8'(s / 8);
        seen3 = 1'b1;
      end
      v0 = 1'b1;
      exp_avg0 = samp;
      seen0 = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    win_q.delete();
    exp_avg3 = '0;
    exp_avg0 = '0;
    seen3 = 1'b0;
    seen0 = 1'b0;
    exp_err = 0;
  endfunction

  task automatic drive(input logic [1:0] c, input logic [7:0] b, input logic f);
    @(negedge clk);
    rx_dv = 1'b1; rx_cnt = c; rx_byte = b; flush = f;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_dv = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sample"}, s3_sample, 8'h00);
    chk({tag, "_sample_dv"}, s3_sample_dv, 1'b0);
    chk({tag, "_avg"}, s3_avg, 8'h00);
    chk({tag, "_avg_dv"}, s3_avg_dv, 1'b0);
    chk({tag, "_err"}, s3_err, 8'h00);
    chk({tag, "_segs"}, {s3_seg1, s3_seg2}, 14'h3FFF);
    chk({tag, "_segs_w1"}, {s0_seg1, s0_seg2}, 14'h3FFF);
    chk({tag, "_avg_dv_w1"}, s0_avg_dv, 1'b0);
  endtask

  task automatic post_checks(input logic v3, input logic v0);
    @(negedge clk);
    chk("avg_dv", s3_avg_dv, v3);
    chk("avg", s3_avg, exp_avg3);
    chk("avg_dv_w1", s0_avg_dv, v0);
    chk("avg_w1", s0_avg, exp_avg0);
    chk("sample_dv_pulse", s3_sample_dv, 1'b0);
    @(negedge clk);
    chk("segs", {s3_seg1, s3_seg2}, exp_segs(seen3, exp_avg3));
    chk("segs_w1", {s0_seg1, s0_seg2}, exp_segs(seen0, exp_avg0));
    chk("avg_dv_pulse", s3_avg_dv, 1'b0);
  endtask

  task automatic do_frame(input logic [7:0] hi, input logic [7:0] lo, input logic fl);
    logic [15:0] w;
    logic [7:0]  samp;
    logic        v3, v0;
    w = {hi, lo};
    samp = w[12:5];
    drive(2'd0, hi, 1'b0);
    drive(2'd1, lo, fl);
    idle();
    chk("sample_dv", s3_sample_dv, 1'b1);
    chk("sample", s3_sample, samp);
    chk("sample_dv_w1", s0_sample_dv, 1'b1);
    model_accept(samp, fl, v3, v0);
    post_checks(v3, v0);
  endtask

  task automatic lone_byte(input logic [1:0] c, input logic [7:0] b, input string tag);
    drive(c, b, 1'b0);
    idle();
    if (exp_err < 255) exp_err++;
    chk({tag, "_err"}, s3_err, 8'(exp_err));
    chk({tag, "_no_sample"}, s3_sample_dv, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_on && s3_sample_dv) begin
      if (exp_q.size() == 0) chk("burst_extra_sample", 1'b1, 1'b0);
      else chk("burst_sample", s3_sample, exp_q.pop_front());
    end
    if (mon_on && s3_avg_dv) begin
      if (exp_avg_q.size() == 0) chk("burst_extra_avg", 1'b1, 1'b0);
      else chk("burst_avg", s3_avg, exp_avg_q.pop_front());
    end
  end

  initial begin
    logic [7:0]  hi, lo;
    logic [15:0] w;
    logic        v3, v0;

    repeat (3) @(negedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the window with a constant; the window-8 average appears only on frame 8.
    for (int k = 0; k < 8; k++) do_frame(8'h0A, 8'hB0, 1'b0);
    chk("avg_const", s3_avg, 8'h55);
    chk("seg1_const", s3_seg1, 7'h12);
    chk("seg2_w1_const", s0_seg2, 7'h12);
    do_frame(8'h0B, 8'hA0, 1'b0);
    chk("avg_step", s3_avg, 8'h56);

    // Flush with a sample after a full window, then refill with random data.
    do_frame(8'h01, 8'hE0, 1'b1);
    chk("flush_avg_hold", s3_avg, 8'h56);
    for (int k = 0; k < 8; k++) do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

    for (int k = 0; k < 24; k++)
      do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));

    // Back-to-back frames with no idle cycles, one sample every two cycles.
    mon_on = 1'b1;
    for (int k = 0; k < 16; k++) begin
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      w = {hi, lo};
      exp_q.push_back(w[12:5]);
      model_accept(w[12:5], 1'b0, v3, v0);
      if (v3) exp_avg_q.push_back(exp_avg3);
      drive(2'd0, hi, 1'b0);
      drive(2'd1, lo, 1'b0);
    end
    idle();
    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    chk("burst_samples_left", exp_q.size(), 0);
    chk("burst_avgs_left", exp_avg_q.size(), 0);
    chk("burst_avg_final", s3_avg, exp_avg3);
    chk("burst_avg_final_w1", s0_avg, exp_avg0);
    chk("burst_segs", {s3_seg1, s3_seg2}, exp_segs(seen3, exp_avg3));

    // Framing errors.
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lone_byte(2'd1, 8'hB0, "lone_lo");
    drive(2'd0, 8'h01, 1'b0);
    lone_byte(2'd0, 8'h0A, "double_hi");
    drive(2'd1, 8'hB0, 1'b0);
    idle();
    chk("double_hi_sample_dv", s3_sample_dv, 1'b1);
    chk("double_hi_sample", s3_sample, 8'h55);
    chk("double_hi_err_hold", s3_err, 8'(exp_err));
    model_accept(8'h55, 1'b0, v3, v0);
    post_checks(v3, v0);
    drive(2'd0, 8'h12, 1'b0);
    lone_byte(2'd2, 8'h34, "cnt2_in_lo");
    lone_byte(2'd1, 8'h56, "lo_after_cnt2");
    drive(2'd0, 8'h12, 1'b0);
    lone_byte(2'd3, 8'h34, "cnt3_in_lo");
    do_frame(8'h1F, 8'hFF, 1'b0);
    chk("err_w1", s0_err, 8'(exp_err));

    for (int k = 0; k < 300; k++) begin
      drive(2'd1, 8'($urandom_range(0, 255)), 1'b0);
      idle();
    end
    chk("err_saturated", s3_err, 8'hFF);
    chk("err_saturated_w1", s0_err, 8'hFF);

    // Reset between a high byte and its low byte.
    drive(2'd0, 8'h0A, 1'b0);
    idle();
    rst_n = 1'b0;
    #1 check_reset_values("midframe_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lone_byte(2'd1, 8'hB0, "late_lo");
    repeat (2) @(negedge clk);
    chk("late_lo_segs", {s3_seg1, s3_seg2}, 14'h3FFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
